// File: rtl/bram_program_loader_if.sv
// Word-addressed memory bus between memory_interface, the program loader
// and the BRAM subsystem data port. The requester is the master; the memory
// side is the slave and returns rdata/raddr/valid/ready.
interface bram_program_loader_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32
);
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH/8-1:0] byte_en;
    logic [ADDRESS_BITS-1:0] address;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [ADDRESS_BITS-1:0] raddr;
    logic                    valid;
    logic                    ready;

    modport master (
        output read, write, byte_en, address, wdata,
        input  rdata, raddr, valid, ready
    );

    modport slave (
        input  read, write, byte_en, address, wdata,
        output rdata, raddr, valid, ready
    );
endinterface

// File: rtl/bram_program_loader.sv
// Boot-time program loader. Holds the core in reset while an image is
// streamed into BRAM, then releases the core with a one-cycle start pulse
// carrying the entry address, and finally becomes a transparent wire between
// the core's data-side port and the BRAM data port.
module bram_program_loader #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDRESS_BITS     = 32,
    parameter int MEM_ADDRESS_BITS = 14
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load_begin,
    input  logic [ADDRESS_BITS-1:0]   load_base,
    input  logic [ADDRESS_BITS-1:0]   load_entry,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [DATA_WIDTH-1:0]     load_data,
    input  logic                      load_last,
    output logic                      core_reset,
    output logic                      core_start,
    output logic [ADDRESS_BITS-1:0]   core_program_addr,
    output logic                      busy,
    output logic                      error,
    output logic [MEM_ADDRESS_BITS:0] word_count,
    bram_program_loader_if.slave      c_bus,
    bram_program_loader_if.master     m_bus
);
    // word_count value at which the BRAM is full; one more write overflows
    localparam logic [MEM_ADDRESS_BITS:0] CAPACITY = {1'b1, {MEM_ADDRESS_BITS{1'b0}}};
    localparam logic [MEM_ADDRESS_BITS:0] ONE      = (MEM_ADDRESS_BITS+1)'(1);

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, START, RUN, ERROR} state_t;

    state_t                  state;
    logic [ADDRESS_BITS-1:0] base_q;
    logic [ADDRESS_BITS-1:0] entry_q;
    logic                    beat;
    logic                    full;

    // an image word is transferred whenever the loader is loading and BRAM is ready
    assign beat = (state == LOAD) && load_valid && m_bus.ready;
    assign full = (word_count == CAPACITY);

    // control FSM with all status outputs registered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            core_reset        <= 1'b1;
            core_start        <= 1'b0;
            busy              <= 1'b0;
            error             <= 1'b0;
            word_count        <= '0;
            core_program_addr <= '0;
            base_q            <= '0;
            entry_q           <= '0;
        end else begin
            case (state)
                IDLE, ERROR: begin
                    if (load_begin) begin
                        base_q     <= load_base;
                        entry_q    <= load_entry;
                        word_count <= '0;
                        error      <= 1'b0;
                        busy       <= 1'b1;
                        core_reset <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        if (full) begin
                            // overflow wins over load_last: the word is dropped
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= ERROR;
                        end else begin
                            word_count <= word_count + ONE;
                            if (load_last) state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // let the BRAM port settle before the core starts issuing traffic
                    if (m_bus.ready) begin
                        core_reset        <= 1'b0;
                        core_start        <= 1'b1;
                        core_program_addr <= entry_q;
                        state             <= START;
                    end
                end
                START: begin
                    core_start <= 1'b0;
                    busy       <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    // terminal until reset
                end
                default: state <= IDLE;
            endcase
        end
    end

    // bus steering: loader writes during LOAD, straight passthrough in RUN, quiet otherwise
    always_comb begin
        load_ready      = 1'b0;
        m_bus.read      = 1'b0;
        m_bus.write     = 1'b0;
        m_bus.byte_en   = '0;
        m_bus.address   = '0;
        m_bus.wdata     = '0;
        c_bus.rdata     = '0;
        c_bus.raddr     = '0;
        c_bus.valid     = 1'b0;
        c_bus.ready     = 1'b0;
        case (state)
            LOAD: begin
                load_ready = m_bus.ready;
                if (beat && !full) begin
                    m_bus.write   = 1'b1;
                    m_bus.byte_en = '1;
                    m_bus.address = base_q + ADDRESS_BITS'(word_count);
                    m_bus.wdata   = load_data;
                end
            end
            RUN: begin
                m_bus.read    = c_bus.read;
                m_bus.write   = c_bus.write;
                m_bus.byte_en = c_bus.byte_en;
                m_bus.address = c_bus.address;
                m_bus.wdata   = c_bus.wdata;
                c_bus.rdata   = m_bus.rdata;
                c_bus.raddr   = m_bus.raddr;
                c_bus.valid   = m_bus.valid;
                c_bus.ready   = m_bus.ready;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_bram_program_loader.sv
// Bench for bram_program_loader: a default-size instance and a 4-word
// instance share the image stream; a behavioural BRAM answers the data port
// and logs every write for comparison with the expected image placement.
module tb_bram_program_loader;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_begin = 1'b0, load_begin2 = 1'b0;
    logic [31:0] load_base = '0, load_entry = '0, load_data = '0;
    logic        load_valid = 1'b0, load_last = 1'b0;
    logic        m_ready = 1'b1;

    logic        load_ready, core_reset, core_start, busy, error;
    logic        load_ready2, core_reset2, core_start2, busy2, error2;
    logic [31:0] core_program_addr, core_program_addr2;
    logic [14:0] word_count;
    logic [2:0]  word_count2;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t         wlog[$];
    wr_t         wlog2[$];
    logic [31:0] img[$];
    logic [31:0] mem [logic [31:0]];

    always #5 clock = ~clock;

    bram_program_loader_if cbus();
    bram_program_loader_if mbus();
    bram_program_loader_if cbus2();
    bram_program_loader_if mbus2();

    assign mbus.ready    = m_ready;
    assign mbus2.ready   = m_ready;
    assign mbus2.valid   = 1'b0;
    assign mbus2.rdata   = '0;
    assign mbus2.raddr   = '0;
    assign cbus2.read    = 1'b0;
    assign cbus2.write   = 1'b0;
    assign cbus2.byte_en = '0;
    assign cbus2.address = '0;
    assign cbus2.wdata   = '0;

    bram_program_loader dut (
        .clock(clock), .reset(reset), .load_begin(load_begin), .load_base(load_base),
        .load_entry(load_entry), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last), .core_reset(core_reset),
        .core_start(core_start), .core_program_addr(core_program_addr), .busy(busy),
        .error(error), .word_count(word_count), .c_bus(cbus), .m_bus(mbus)
    );

    bram_program_loader #(.MEM_ADDRESS_BITS(2)) dut2 (
        .clock(clock), .reset(reset), .load_begin(load_begin2), .load_base(load_base),
        .load_entry(load_entry), .load_valid(load_valid), .load_ready(load_ready2),
        .load_data(load_data), .load_last(load_last), .core_reset(core_reset2),
        .core_start(core_start2), .core_program_addr(core_program_addr2), .busy(busy2),
        .error(error2), .word_count(word_count2), .c_bus(cbus2), .m_bus(mbus2)
    );

    // behavioural BRAM: write logs, one-cycle read latency
    always @(posedge clock) begin
        if (mbus.write && mbus.ready) begin
            wlog.push_back(wr_t'{mbus.address, mbus.wdata});
            mem[mbus.address] = mbus.wdata;
        end
        if (mbus2.write && mbus2.ready) wlog2.push_back(wr_t'{mbus2.address, mbus2.wdata});
        if (reset) mbus.valid <= 1'b0;
        else       mbus.valid <= mbus.read && mbus.ready;
        if (mbus.read && mbus.ready) begin
            mbus.rdata <= mem.exists(mbus.address) ? mem[mbus.address] : 32'h0;
            mbus.raddr <= mbus.address;
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        load_valid = 1'b0; load_last = 1'b0; m_ready = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic begin_load(input int sel, input logic [31:0] base, input logic [31:0] entry);
        @(negedge clock);
        load_base = base; load_entry = entry;
        if (sel != 0) load_begin2 = 1'b1; else load_begin = 1'b1;
        @(negedge clock);
        load_begin = 1'b0; load_begin2 = 1'b0;
    endtask

    // offers img[] word by word; load_ready must track m_ready while loading
    task automatic stream(input int sel, input bit toggle, input bit gaps, input bit use_last, output int accepted);
        int i = 0;
        int cyc = 0;
        logic lr;
        while (i < img.size() && cyc < 400) begin
            @(negedge clock);
            cyc++;
            m_ready    = toggle ? ~m_ready : 1'b1;
            load_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            load_data  = img[i];
            load_last  = use_last && (i == img.size() - 1);
            #1;
            lr = (sel != 0) ? load_ready2 : load_ready;
            checks++;
            if (lr !== m_ready) begin
                errors++;
                $display("FAIL load_ready cycle %0d: got %b, want %b", cyc, lr, m_ready);
            end
            if (load_valid && lr) i++;
        end
        if (i < img.size()) begin
            checks++; errors++;
            $display("FAIL stream_timeout: accepted %0d, want %0d", i, img.size());
        end
        @(negedge clock);
        load_valid = 1'b0; load_last = 1'b0; m_ready = 1'b1;
        accepted = i;
    endtask

    task automatic wait_start(input int sel, output int starts, output logic rst_in_start, output logic [31:0] pa);
        starts = 0; rst_in_start = 1'b1; pa = '0;
        repeat (20) begin
            @(negedge clock); #1;
            if ((sel != 0) ? core_start2 : core_start) begin
                starts++;
                rst_in_start = (sel != 0) ? core_reset2 : core_reset;
                pa = (sel != 0) ? core_program_addr2 : core_program_addr;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock); #1;
        checks++;
        if ({core_reset, core_start, load_ready, busy, error, mbus.read, mbus.write, cbus.valid, cbus.ready} !== 9'b100000000) begin
            errors++;
            $display("FAIL reset_flags: got %b, want 100000000",
                     {core_reset, core_start, load_ready, busy, error, mbus.read, mbus.write, cbus.valid, cbus.ready});
        end
        checks++;
        if (word_count !== 15'd0 || core_program_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_counts: word_count %0d addr %h, want 0 0", word_count, core_program_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_load();
        int acc, starts;
        logic r;
        logic [31:0] pa;
        do_reset();
        wlog.delete();
        begin_load(0, 32'h100, 32'h400);
        #1;
        checks++;
        if (busy !== 1'b1 || core_reset !== 1'b1) begin
            errors++; $display("FAIL load_busy: busy %b core_reset %b, want 1 1", busy, core_reset);
        end
        img.delete();
        for (int k = 0; k < 4; k++) img.push_back(32'hA0 + 32'(k));
        stream(0, 1'b0, 1'b0, 1'b1, acc);
        wait_start(0, starts, r, pa);
        checks++;
        if (wlog.size() != 4) begin
            errors++; $display("FAIL basic_write_count: got %0d, want 4", wlog.size());
        end
        for (int k = 0; k < 4 && k < wlog.size(); k++) begin
            checks++;
            if (wlog[k].a !== 32'h100 + 32'(k) || wlog[k].d !== 32'hA0 + 32'(k)) begin
                errors++; $display("FAIL basic_write %0d: got %h/%h, want %h/%h", k, wlog[k].a, wlog[k].d, 32'h100 + 32'(k), 32'hA0 + 32'(k));
            end
        end
        checks++;
        if (word_count !== 15'd4) begin
            errors++; $display("FAIL basic_word_count: got %0d, want 4", word_count);
        end
        checks++;
        if (starts != 1 || r !== 1'b0 || pa !== 32'h400) begin
            errors++; $display("FAIL basic_start: pulses %0d core_reset %b addr %h, want 1 0 400", starts, r, pa);
        end
        checks++;
        if (core_reset !== 1'b0 || busy !== 1'b0 || core_program_addr !== 32'h400) begin
            errors++; $display("FAIL basic_run: core_reset %b busy %b addr %h, want 0 0 400", core_reset, busy, core_program_addr);
        end
    endtask

    task automatic test_run_passthrough();
        logic [31:0] a, d;
        @(negedge clock);
        cbus.read = 1'b1; cbus.address = 32'h101; cbus.byte_en = 4'hF;
        #1;
        checks++;
        if (mbus.read !== 1'b1 || mbus.address !== 32'h101 || cbus.ready !== 1'b1) begin
            errors++; $display("FAIL run_read_req: read %b addr %h ready %b, want 1 101 1", mbus.read, mbus.address, cbus.ready);
        end
        @(negedge clock);
        cbus.read = 1'b0;
        #1;
        checks++;
        if (cbus.valid !== 1'b1 || cbus.rdata !== 32'hA1 || cbus.raddr !== 32'h101) begin
            errors++; $display("FAIL run_read_resp: valid %b data %h addr %h, want 1 a1 101", cbus.valid, cbus.rdata, cbus.raddr);
        end
        a = 32'h2000 + 32'($urandom_range(0, 255));
        d = $urandom;
        @(negedge clock);
        cbus.write = 1'b1; cbus.address = a; cbus.wdata = d;
        #1;
        checks++;
        if (mbus.write !== 1'b1 || mbus.wdata !== d || mbus.byte_en !== 4'hF) begin
            errors++; $display("FAIL run_write_req: write %b data %h be %h, want 1 %h f", mbus.write, mbus.wdata, mbus.byte_en, d);
        end
        @(negedge clock);
        cbus.write = 1'b0; cbus.read = 1'b1;
        @(negedge clock);
        cbus.read = 1'b0;
        #1;
        checks++;
        if (cbus.valid !== 1'b1 || cbus.rdata !== d) begin
            errors++; $display("FAIL run_readback: valid %b data %h, want 1 %h", cbus.valid, cbus.rdata, d);
        end
        m_ready = 1'b0;
        #1;
        checks++;
        if (cbus.ready !== 1'b0) begin
            errors++; $display("FAIL run_ready: got %b, want 0", cbus.ready);
        end
        m_ready = 1'b1;
        begin_load(0, 32'h0, 32'h999);
        @(negedge clock); #1;
        checks++;
        if (busy !== 1'b0 || core_reset !== 1'b0 || word_count !== 15'd4 || core_program_addr !== 32'h400 || mbus.write !== 1'b0) begin
            errors++; $display("FAIL run_ignores_begin: busy %b rst %b wc %0d addr %h wr %b, want 0 0 4 400 0",
                               busy, core_reset, word_count, core_program_addr, mbus.write);
        end
    endtask

    task automatic test_backpressure();
        int acc, starts, n;
        logic r;
        logic [31:0] pa, base, entry;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            wlog.delete();
            base  = (it == 0) ? 32'hFFFF_FFFE : $urandom;
            entry = $urandom;
            n     = 5 + $urandom_range(0, 7);
            img.delete();
            for (int k = 0; k < n; k++) img.push_back($urandom);
            begin_load(0, base, entry);
            stream(0, 1'b1, 1'b1, 1'b1, acc);
            wait_start(0, starts, r, pa);
            checks++;
            if (wlog.size() != n) begin
                errors++; $display("FAIL bp_write_count it %0d: got %0d, want %0d", it, wlog.size(), n);
            end
            for (int k = 0; k < n && k < wlog.size(); k++) begin
                checks++;
                if (wlog[k].a !== base + 32'(k) || wlog[k].d !== img[k]) begin
                    errors++; $display("FAIL bp_write it %0d #%0d: got %h/%h, want %h/%h", it, k, wlog[k].a, wlog[k].d, base + 32'(k), img[k]);
                end
            end
            checks++;
            if (word_count !== 15'(n) || starts != 1 || pa !== entry) begin
                errors++; $display("FAIL bp_finish it %0d: wc %0d pulses %0d addr %h, want %0d 1 %h", it, word_count, starts, pa, n, entry);
            end
        end
    endtask

    task automatic test_core_blocked();
        int acc, starts;
        logic r;
        logic [31:0] pa;
        do_reset();
        wlog.delete();
        begin_load(0, 32'h300, 32'h10);
        cbus.write = 1'b1; cbus.read = 1'b1; cbus.address = 32'h55; cbus.wdata = 32'hDEAD;
        #1;
        checks++;
        if (mbus.write !== 1'b0 || mbus.read !== 1'b0 || cbus.ready !== 1'b0 || cbus.valid !== 1'b0) begin
            errors++; $display("FAIL blocked_idle_beat: m_wr %b m_rd %b c_rdy %b c_vld %b, want 0 0 0 0",
                               mbus.write, mbus.read, cbus.ready, cbus.valid);
        end
        img.delete();
        for (int k = 0; k < 3; k++) img.push_back($urandom);
        stream(0, 1'b0, 1'b1, 1'b1, acc);
        #1;
        checks++;
        if (mbus.write !== 1'b0 || cbus.ready !== 1'b0) begin
            errors++; $display("FAIL blocked_drain: m_wr %b c_rdy %b, want 0 0", mbus.write, cbus.ready);
        end
        cbus.write = 1'b0; cbus.read = 1'b0;
        wait_start(0, starts, r, pa);
        checks++;
        if (wlog.size() != 3) begin
            errors++; $display("FAIL blocked_count: got %0d writes, want 3", wlog.size());
        end
        for (int k = 0; k < 3 && k < wlog.size(); k++) begin
            checks++;
            if (wlog[k].a !== 32'h300 + 32'(k) || wlog[k].d !== img[k]) begin
                errors++; $display("FAIL blocked_write %0d: got %h/%h, want %h/%h", k, wlog[k].a, wlog[k].d, 32'h300 + 32'(k), img[k]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int acc;
        do_reset();
        wlog.delete();
        begin_load(0, 32'h500, 32'h20);
        img.delete();
        img.push_back(32'h11); img.push_back(32'h22);
        stream(0, 1'b0, 1'b0, 1'b0, acc);
        @(negedge clock);
        load_valid = 1'b1; load_data = 32'h33; m_ready = 1'b1;
        #1;
        checks++;
        if (mbus.write !== 1'b1 || mbus.address !== 32'h502) begin
            errors++; $display("FAIL mid_third_beat: wr %b addr %h, want 1 502", mbus.write, mbus.address);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mbus.write !== 1'b0 || busy !== 1'b0 || word_count !== 15'd0 || core_reset !== 1'b1 || load_ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset: wr %b busy %b wc %0d rst %b lr %b, want 0 0 0 1 0",
                               mbus.write, busy, word_count, core_reset, load_ready);
        end
        @(negedge clock);
        load_valid = 1'b0;
        reset = 1'b0;
        checks++;
        if (wlog.size() != 2) begin
            errors++; $display("FAIL mid_partial: got %0d writes, want 2", wlog.size());
        end
    endtask

    task automatic test_overflow();
        int acc, starts;
        logic r;
        logic [31:0] pa;
        checks++;
        if (wlog2.size() != 0) begin
            errors++; $display("FAIL ovf_idle_ignored: got %0d writes, want 0", wlog2.size());
        end
        begin_load(1, 32'h40, 32'h77);
        img.delete();
        for (int k = 0; k < 5; k++) img.push_back($urandom);
        stream(1, 1'b0, 1'b0, 1'b0, acc);
        load_valid = 1'b1;
        #1;
        checks++;
        if (error2 !== 1'b1 || core_reset2 !== 1'b1 || busy2 !== 1'b0 || load_ready2 !== 1'b0 || word_count2 !== 3'd4) begin
            errors++; $display("FAIL ovf_state: err %b rst %b busy %b lr %b wc %0d, want 1 1 0 0 4",
                               error2, core_reset2, busy2, load_ready2, word_count2);
        end
        load_valid = 1'b0;
        checks++;
        if (wlog2.size() != 4) begin
            errors++; $display("FAIL ovf_count: got %0d writes, want 4", wlog2.size());
        end
        for (int k = 0; k < 4 && k < wlog2.size(); k++) begin
            checks++;
            if (wlog2[k].a !== 32'h40 + 32'(k) || wlog2[k].d !== img[k]) begin
                errors++; $display("FAIL ovf_write %0d: got %h/%h, want %h/%h", k, wlog2[k].a, wlog2[k].d, 32'h40 + 32'(k), img[k]);
            end
        end
        wlog2.delete();
        begin_load(1, 32'h10, 32'h88);
        #1;
        checks++;
        if (error2 !== 1'b0 || busy2 !== 1'b1) begin
            errors++; $display("FAIL ovf_restart: err %b busy %b, want 0 1", error2, busy2);
        end
        img.delete();
        for (int k = 0; k < 3; k++) img.push_back($urandom);
        stream(1, 1'b0, 1'b0, 1'b1, acc);
        wait_start(1, starts, r, pa);
        checks++;
        if (starts != 1 || pa !== 32'h88 || error2 !== 1'b0 || core_reset2 !== 1'b0 || wlog2.size() != 3) begin
            errors++; $display("FAIL ovf_reload: pulses %0d addr %h err %b rst %b writes %0d, want 1 88 0 0 3",
                               starts, pa, error2, core_reset2, wlog2.size());
        end
        for (int k = 0; k < 3 && k < wlog2.size(); k++) begin
            checks++;
            if (wlog2[k].a !== 32'h10 + 32'(k) || wlog2[k].d !== img[k]) begin
                errors++; $display("FAIL ovf_reload_write %0d: got %h/%h, want %h/%h", k, wlog2[k].a, wlog2[k].d, 32'h10 + 32'(k), img[k]);
            end
        end
    endtask

    initial begin
        cbus.read = 1'b0; cbus.write = 1'b0; cbus.byte_en = '0;
        cbus.address = '0; cbus.wdata = '0;
        test_reset();
        test_basic_load();
        test_run_passthrough();
        test_backpressure();
        test_core_blocked();
        test_reset_mid_load();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end
endmodule
